// File: rtl/gate_response_checker.sv
// Response checker for a basic-gate DUT: captures each applied vector, waits for
// the DUT output to settle, compares it with the selected gate function and reports a verdict.
module gate_response_checker #(
  parameter int unsigned GATE_SEL    = 0,
  parameter int unsigned NUM_VECTORS = 20,
  parameter int unsigned SETTLE_CYC  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic             overrun,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_fail
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t           state;
  logic [SET_W-1:0] settle_cnt;
  logic             a_q;
  logic             b_q;

  logic             exp_c;
  logic             miss_c;
  logic [CNT_W-1:0] vec_next_c;
  logic [CNT_W-1:0] err_next_c;

  // Reference truth table for the gate under test
  function automatic logic gate_fn(input logic a, input logic b);
    logic r;
    case (GATE_SEL)
      0:       r = ~a;
      1:       r = a & b;
      2:       r = a | b;
      3:       r = ~(a & b);
      4:       r = ~(a | b);
      5:       r = a ^ b;
      6:       r = ~(a ^ b);
      default: r = a;
    endcase
    return r;
  endfunction

  // Compare result and next counter values used on the CHECK edge
  always_comb begin
    exp_c      = gate_fn(a_q, b_q);
    miss_c     = (dut_out != exp_c);
    vec_next_c = vec_cnt + CNT_W'(1);
    err_next_c = err_cnt;
    if (miss_c && (err_cnt != ALL_ONES)) begin
      err_next_c = err_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      mismatch   <= 1'b0;
      overrun    <= 1'b0;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      first_fail <= ALL_ONES;
    end else begin
      done     <= 1'b0;
      mismatch <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ARM;
            busy       <= 1'b1;
            vec_cnt    <= '0;
            err_cnt    <= '0;
            overrun    <= 1'b0;
            pass       <= 1'b0;
            first_fail <= ALL_ONES;
          end
        end
        ARM: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            settle_cnt <= SET_W'(SETTLE_CYC);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // A new vector while the previous one is still settling is dropped
          if (in_valid) begin
            overrun <= 1'b1;
          end
          settle_cnt <= settle_cnt - SET_W'(1);
          if (settle_cnt == SET_W'(1)) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          if (miss_c) begin
            mismatch <= 1'b1;
            err_cnt  <= err_next_c;
            if (first_fail == ALL_ONES) begin
              first_fail <= vec_cnt;
            end
          end
          vec_cnt <= vec_next_c;
          if (vec_next_c == LAST_VEC) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next_c == '0) && !overrun;
          end else begin
            state <= ARM;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: four instances with different
// parameters, expected compare results queued at drive time and checked at output.
module tb_gate_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] start;
  logic       in_valid, in_a, in_b, dut_out;
  logic [3:0] busy_w, done_w, pass_w, mism_w, ovr_w;
  logic [7:0] vec_w [4];
  logic [7:0] err_w [4];
  logic [7:0] ff_w  [4];

  // 0: NOT settle1 N20, 1: XOR settle1 N20, 2: NOT settle3 N20, 3: NOT settle1 N1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    gate_response_checker #(
      .GATE_SEL   ((g == 1) ? 5 : 0),
      .NUM_VECTORS((g == 3) ? 1 : 20),
      .SETTLE_CYC ((g == 2) ? 3 : 1),
      .CNT_W      (8)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .in_valid  (in_valid),
      .in_a      (in_a),
      .in_b      (in_b),
      .dut_out   (dut_out),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .pass      (pass_w[g]),
      .mismatch  (mism_w[g]),
      .overrun   (ovr_w[g]),
      .vec_cnt   (vec_w[g]),
      .err_cnt   (err_w[g]),
      .first_fail(ff_w[g])
    );
  end

  typedef struct {
    logic mism;
    int   idx;
  } exp_t;

  exp_t q[$];
  int   sel = 0;
  int   passed = 0, total = 0, failed = 0;
  int   done_seen = 0, mism_seen = 0;
  int   done_base, mism_base;
  int   vcount;
  logic done_at_obs;

  always @(posedge clk) begin
    if (done_w[sel]) done_seen++;
    if (mism_w[sel]) mism_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model(input int gs, input logic a, input logic b);
    case (gs)
      0: return !a;
      5: return a != b;
      default: return a;
    endcase
  endfunction

  function automatic int gate_of(input int s);
    return (s == 1) ? 5 : 0;
  endfunction

  task automatic run_start();
    @(negedge clk);
    start[sel] = 1'b1;
    vcount     = 0;
    done_base  = done_seen;
    mism_base  = mism_seen;
    @(negedge clk);
    start[sel] = 1'b0;
    check("busy_after_start", 32'(busy_w[sel]), 1);
  endtask

  // Drive one vector, queue its expected result, then wait for the compare
  task automatic apply_vec(input logic a, input logic b, input logic d,
                           input bit dbl, input bit start_mid);
    exp_t e;
    bit   got;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    dut_out  = d;
    q.push_back('{mism: (d !== model(gate_of(sel), a, b)), idx: vcount + 1});
    @(negedge clk);
    if (dbl) @(negedge clk);
    in_valid = 1'b0;
    if (start_mid) begin
      start[sel] = 1'b1;
      @(negedge clk);
      start[sel] = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (vec_w[sel] !== 8'(vcount)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("compare_seen", 32'(got), 1);
    e = q.pop_front();
    check("mismatch", 32'(mism_w[sel]), 32'(e.mism));
    check("vec_cnt", 32'(vec_w[sel]), 32'(e.idx));
    done_at_obs = done_w[sel];
    vcount++;
  endtask

  task automatic finish_run(input int e_err, input int e_ff, input int e_pass,
                            input int e_ovr, input int e_vec, input int e_mism);
    check("done_after_last", 32'(done_at_obs), 1);
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_seen - done_base), 1);
    check("busy_idle", 32'(busy_w[sel]), 0);
    check("pass", 32'(pass_w[sel]), 32'(e_pass));
    check("err_cnt", 32'(err_w[sel]), 32'(e_err));
    check("first_fail", 32'(ff_w[sel]), 32'(e_ff));
    check("overrun", 32'(ovr_w[sel]), 32'(e_ovr));
    check("vec_final", 32'(vec_w[sel]), 32'(e_vec));
    check("mism_pulses", 32'(mism_seen - mism_base), 32'(e_mism));
  endtask

  initial begin
    rst_n = 1'b0; start = '0; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; dut_out = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_w[0]), 0);
    check("rst_pass", 32'(pass_w[0]), 0);
    check("rst_vec", 32'(vec_w[0]), 0);
    check("rst_ff", 32'(ff_w[0]), 32'hFF);
    rst_n = 1'b1;

    // NOT gate, correct DUT
    sel = 0;
    run_start();
    for (int i = 0; i < 20; i++) begin
      apply_vec(1'(i), 1'b0, !1'(i), 0, 0);
      repeat (2) @(negedge clk);
    end
    finish_run(0, 8'hFF, 1, 0, 20, 0);

    // NOT gate, output stuck at 0
    run_start();
    for (int i = 0; i < 20; i++) apply_vec(1'(i), 1'b0, 1'b0, 0, 0);
    finish_run(10, 0, 0, 0, 20, 10);

    // XOR gate, vector 6 inverted
    sel = 1;
    run_start();
    for (int i = 0; i < 20; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      apply_vec(ab[1], ab[0], (ab[1] ^ ab[0]) ^ (i == 6), 0, 0);
    end
    finish_run(1, 6, 0, 0, 20, 1);

    // Settle of 3 with a back-to-back vector causing overrun
    sel = 2;
    run_start();
    apply_vec(1'b0, 1'b0, 1'b1, 1, 0);
    check("overrun_set", 32'(ovr_w[2]), 1);
    for (int i = 1; i < 20; i++) apply_vec(1'(i), 1'b0, !1'(i), 0, 0);
    finish_run(0, 8'hFF, 0, 1, 20, 0);

    // Asynchronous reset mid-run, then a clean run
    sel = 0;
    run_start();
    for (int i = 0; i < 7; i++) apply_vec(1'(i), 1'b0, !1'(i), 0, 0);
    check("pre_reset_vec", 32'(vec_w[0]), 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy_w[0]), 0);
    check("arst_vec", 32'(vec_w[0]), 0);
    check("arst_err", 32'(err_w[0]), 0);
    check("arst_ff", 32'(ff_w[0]), 32'hFF);
    check("arst_done", 32'(done_w[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_no_done", 32'(done_seen - done_base), 0);
    run_start();
    for (int i = 0; i < 20; i++) apply_vec(1'(i), 1'b0, !1'(i), 0, 0);
    finish_run(0, 8'hFF, 1, 0, 20, 0);

    // start during SETTLE ignored; counting continues
    run_start();
    apply_vec(1'b1, 1'b0, 1'b0, 0, 1);
    apply_vec(1'b0, 1'b0, 1'b1, 0, 0);
    check("start_ignored_busy", 32'(busy_w[0]), 1);

    // Single-vector run: done right after CHECK
    sel = 3;
    run_start();
    apply_vec(1'b0, 1'b0, 1'b1, 0, 0);
    finish_run(0, 8'hFF, 1, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
